// File: rtl/dilithium_pkg.sv
// Shared constants and modular add/sub helpers for the Dilithium NTT datapath.
package dilithium_pkg;

    localparam int               COEF_W      = 23;
    localparam logic [COEF_W-1:0] Q          = 23'd8380417;
    localparam int               BFU_LATENCY = 11;
    localparam int               MUL_LATENCY = 8;

    // (x + y) mod q for x, y in [0, q-1], using a 24-bit intermediate.
    function automatic logic [COEF_W-1:0] mod_add(input logic [COEF_W-1:0] x,
                                                   input logic [COEF_W-1:0] y);
        logic [COEF_W:0] sum;
        sum = {1'b0, x} + {1'b0, y};
        if (sum >= {1'b0, Q}) begin
            sum = sum - {1'b0, Q};
        end
        return sum[COEF_W-1:0];
    endfunction

    // (x - y) mod q for x, y in [0, q-1]; bit 23 flags a negative difference.
    function automatic logic [COEF_W-1:0] mod_sub(input logic [COEF_W-1:0] x,
                                                   input logic [COEF_W-1:0] y);
        logic [COEF_W:0] diff;
        diff = {1'b0, x} - {1'b0, y};
        if (diff[COEF_W]) begin
            diff = diff + {1'b0, Q};
        end
        return diff[COEF_W-1:0];
    endfunction

endpackage

// File: rtl/mod_mul_q.sv
// Pipelined modular multiplier mod q with fixed 8-cycle latency.
// x in [0, q], y in [0, q]; z fully reduced to [0, q-1].
// Reduction folds the high part using 2^23 = 2^13 - 1 (mod q) three times,
// then one conditional subtraction finishes the job.
module mod_mul_q
    import dilithium_pkg::*;
(
    input  logic              clk,
    input  logic [COEF_W-1:0] x,
    input  logic [COEF_W-1:0] y,
    output logic [COEF_W-1:0] z
);

    logic [22:0] x_r;
    logic [22:0] y_r;
    logic [34:0] prod_lo;
    logic [33:0] prod_hi;
    logic [45:0] prod;
    logic [37:0] fold1;
    logic [28:0] fold2;
    logic [23:0] fold3;
    logic [22:0] corr;

    // Operand capture, split multiply, three folds, correction and output register.
    always_ff @(posedge clk) begin
        x_r     <= x;
        y_r     <= y;
        prod_lo <= 35'(x_r) * 35'(y_r[11:0]);
        prod_hi <= 34'(x_r) * 34'(y_r[22:12]);
        prod    <= 46'(prod_lo) + (46'(prod_hi) << 12);
        fold1   <= 38'(prod[22:0]) + (38'(prod[45:23]) << 13) - 38'(prod[45:23]);
        fold2   <= 29'(fold1[22:0]) + (29'(fold1[37:23]) << 13) - 29'(fold1[37:23]);
        fold3   <= 24'(fold2[22:0]) + (24'(fold2[28:23]) << 13) - 24'(fold2[28:23]);
        corr    <= (fold3 >= {1'b0, Q}) ? 23'(fold3 - {1'b0, Q}) : fold3[22:0];
        z       <= corr;
    end

endmodule

// File: rtl/bfu_dual_mode_q.sv
// Dual-mode (CT/DIT and GS/DIF) radix-2 butterfly mod q, fully pipelined.
// Stages: input register, DIF pre-add/sub, 8-stage modular multiply,
// DIT post-add/sub into the output register. The mode travels with each sample.
module bfu_dual_mode_q
    import dilithium_pkg::*;
#(
    parameter int LATENCY = BFU_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              sel,
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    input  logic [COEF_W-1:0] omiga,
    output logic              out_valid,
    output logic [COEF_W-1:0] a1,
    output logic [COEF_W-1:0] b1
);

    if (LATENCY != BFU_LATENCY) begin : g_latency_check
        $error("bfu_dual_mode_q only supports LATENCY = %0d", BFU_LATENCY);
    end

    logic                    in_v;
    logic                    in_sel;
    logic [COEF_W-1:0]       in_a;
    logic [COEF_W-1:0]       in_b;
    logic [COEF_W-1:0]       in_w;

    logic                    pre_v;
    logic                    pre_sel;
    logic [COEF_W-1:0]       mul_x;
    logic [COEF_W-1:0]       mul_w;
    logic [COEF_W-1:0]       pre_byp;

    logic [MUL_LATENCY-1:0]  mul_v;
    logic [MUL_LATENCY-1:0]  mul_sel;
    logic [COEF_W-1:0]       byp_pipe [MUL_LATENCY];
    logic [COEF_W-1:0]       mul_z;

    logic [COEF_W-1:0]       post_a;
    logic [COEF_W-1:0]       post_b;

    // Valid chain and output registers; resetting these discards every in-flight sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_v      <= 1'b0;
            pre_v     <= 1'b0;
            mul_v     <= '0;
            out_valid <= 1'b0;
            a1        <= '0;
            b1        <= '0;
        end else begin
            in_v      <= in_valid;
            pre_v     <= in_v;
            mul_v     <= {mul_v[MUL_LATENCY-2:0], pre_v};
            out_valid <= mul_v[MUL_LATENCY-1];
            if (mul_v[MUL_LATENCY-1]) begin
                a1 <= post_a;
                b1 <= post_b;
            end
        end
    end

    // Data path registers: input capture, mode-dependent pre-stage, bypass delay line.
    always_ff @(posedge clk) begin
        in_sel  <= sel;
        in_a    <= a;
        in_b    <= b;
        in_w    <= omiga;
        pre_sel <= in_sel;
        mul_w   <= in_w;
        if (in_sel) begin
            mul_x   <= mod_sub(in_a, in_b);
            pre_byp <= mod_add(in_a, in_b);
        end else begin
            mul_x   <= in_b;
            pre_byp <= in_a;
        end
        mul_sel     <= {mul_sel[MUL_LATENCY-2:0], pre_sel};
        byp_pipe[0] <= pre_byp;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            byp_pipe[i] <= byp_pipe[i-1];
        end
    end

    mod_mul_q u_mul (
        .clk (clk),
        .x   (mul_x),
        .y   (mul_w),
        .z   (mul_z)
    );

    // Post stage: DIT combines a with the product, DIF passes the sum and product through.
    always_comb begin
        post_a = byp_pipe[MUL_LATENCY-1];
        post_b = mul_z;
        if (!mul_sel[MUL_LATENCY-1]) begin
            post_a = mod_add(byp_pipe[MUL_LATENCY-1], mul_z);
            post_b = mod_sub(byp_pipe[MUL_LATENCY-1], mul_z);
        end
    end

endmodule

// File: tb/tb_bfu_dual_mode_q.sv
// Scoreboard bench for bfu_dual_mode_q: stimulus pushes expected results,
// a monitor pops and compares whenever out_valid is seen.
module tb_bfu_dual_mode_q;
    import dilithium_pkg::*;

    localparam longint QL = 64'd8380417;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        sel;
    logic [22:0] a;
    logic [22:0] b;
    logic [22:0] omiga;
    logic        out_valid;
    logic [22:0] a1;
    logic [22:0] b1;

    typedef struct {
        logic [22:0] a1;
        logic [22:0] b1;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_e;
    logic [15:0] vhist = '0;
    int          total = 0;
    int          bad = 0;

    bfu_dual_mode_q #(.LATENCY(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .omiga     (omiga),
        .out_valid (out_valid),
        .a1        (a1),
        .b1        (b1)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Butterfly result from the arithmetic definition using wide integers.
    function automatic exp_t model(input logic s, input longint av, input longint bv, input longint wv);
        exp_t   r;
        longint t;
        longint d;
        if (!s) begin
            t    = (wv * bv) % QL;
            r.a1 = 23'((av + t) % QL);
            r.b1 = 23'((av - t + QL) % QL);
        end else begin
            d    = (av - bv + QL) % QL;
            r.a1 = 23'((av + bv) % QL);
            r.b1 = 23'((d * wv) % QL);
        end
        return r;
    endfunction

    // Random coefficient up to max, biased towards 0 and max.
    function automatic logic [22:0] rand_coef(input int max);
        int r;
        r = $urandom_range(7, 0);
        if (r == 0) return 23'd0;
        if (r == 1) return 23'(max);
        return 23'($urandom_range(max, 0));
    endfunction

    task automatic check_output(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle; valid samples push the model result.
    task automatic apply_stimulus(input logic v, input logic s, input logic [22:0] av,
                                  input logic [22:0] bv, input logic [22:0] wv);
        @(negedge clk);
        in_valid = v;
        sel      = s;
        a        = av;
        b        = bv;
        omiga    = wv;
        if (v) exp_q.push_back(model(s, longint'(av), longint'(bv), longint'(wv)));
    endtask

    // Drive one valid sample whose expected result is given explicitly.
    task automatic apply_directed(input logic s, input logic [22:0] av, input logic [22:0] bv,
                                  input logic [22:0] wv, input logic [22:0] ea, input logic [22:0] eb);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        sel      = s;
        a        = av;
        b        = bv;
        omiga    = wv;
        e.a1     = ea;
        e.b1     = eb;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 23'd0, 23'd0, 23'd0);
    endtask

    // Monitor: out_valid must equal in_valid 11 cycles earlier; valid outputs pop the scoreboard.
    always @(posedge clk) begin
        if (rst) vhist = '0;
        else     vhist = {vhist[14:0], in_valid};
        #2;
        if (rst) begin
            exp_q.delete();
            check_output("reset_out_valid", longint'(out_valid), 0);
            check_output("reset_a1", longint'(a1), 0);
            check_output("reset_b1", longint'(b1), 0);
        end else begin
            check_output("out_valid_pattern", longint'(out_valid), longint'(vhist[10]));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_output", 1, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_output("a1", longint'(a1), longint'(exp_e.a1));
                    check_output("b1", longint'(b1), longint'(exp_e.b1));
                end
            end
        end
    end

    // Main sequence: reset, directed cases, random stream, mid-stream reset, drain.
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sel      = 1'b0;
        a        = '0;
        b        = '0;
        omiga    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        apply_directed(1'b0, 23'd1, 23'd2, 23'd3, 23'd7, 23'd8380412);
        idle(14);
        apply_directed(1'b1, 23'd5, 23'd3, 23'd10, 23'd8, 23'd20);
        apply_directed(1'b0, 23'd8380416, 23'd1, 23'd1, 23'd0, 23'd8380415);
        apply_directed(1'b1, 23'd0, 23'd1, 23'd1, 23'd1, 23'd8380416);
        apply_directed(1'b0, 23'd4, 23'd9, 23'd8380417, 23'd4, 23'd4);
        apply_directed(1'b0, 23'd0, 23'd8380416, 23'd8380416, 23'd1, 23'd8380416);
        idle(3);

        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(3, 0) == 0) idle(1);
            apply_stimulus(1'b1, 1'(i), rand_coef(int'(Q) - 1), rand_coef(int'(Q) - 1),
                           rand_coef(int'(Q)));
        end
        idle(14);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'(i), rand_coef(int'(Q) - 1), rand_coef(int'(Q) - 1),
                           rand_coef(int'(Q)));
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check_output("rst_immediate_out_valid", longint'(out_valid), 0);
        check_output("rst_immediate_a1", longint'(a1), 0);
        check_output("rst_immediate_b1", longint'(b1), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(4);
        apply_stimulus(1'b1, 1'b1, 23'd100, 23'd200, 23'd3);
        idle(15);

        check_output("queue_drain", longint'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
